// File: rtl/cursor_move_ctrl.sv
// Cursor position owner for the 8x8 board. Turns held direction keys into single
// moves with auto-repeat, and sequences an erase/draw request pair to the
// cell-draw engine for every move.
module cursor_move_ctrl #(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000,
  parameter int unsigned COORD_MAX    = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_right,
  input  logic       key_left,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       lock,
  input  logic       draw_ready,
  output logic       draw_req,
  output logic [2:0] draw_x,
  output logic [2:0] draw_y,
  output logic       draw_erase,
  output logic [2:0] cur_x,
  output logic [2:0] cur_y,
  output logic       busy
);

  localparam int unsigned CntW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  localparam logic [CntW-1:0] DelayLoad = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RateLoad  = CntW'(REPEAT_RATE - 1);
  localparam logic [2:0]      CoordMax  = 3'(COORD_MAX);

  localparam logic [2:0] StInit  = 3'd0;
  localparam logic [2:0] StIdle  = 3'd1;
  localparam logic [2:0] StErase = 3'd2;
  localparam logic [2:0] StDraw  = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [2:0]      cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [2:0]      old_x_q, old_x_d, old_y_q, old_y_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rpt_q, rpt_d;
  logic            req_q, req_d;
  logic [2:0]      dx_q, dx_d, dy_q, dy_d;
  logic            erase_q, erase_d;

  logic            xfer;
  logic            any_key;
  logic            mv_ok;
  logic [2:0]      nx, ny;

  assign xfer    = req_q & draw_ready;
  assign any_key = key_right | key_left | key_up | key_down;

  // Pick one direction (right > left > up > down) and check it stays on the board.
  always_comb begin
    mv_ok = 1'b0;
    nx    = cur_x_q;
    ny    = cur_y_q;
    if (key_right) begin
      mv_ok = (cur_x_q < CoordMax);
      nx    = cur_x_q + 3'd1;
    end else if (key_left) begin
      mv_ok = (cur_x_q != 3'd0);
      nx    = cur_x_q - 3'd1;
    end else if (key_up) begin
      mv_ok = (cur_y_q != 3'd0);
      ny    = cur_y_q - 3'd1;
    end else if (key_down) begin
      mv_ok = (cur_y_q < CoordMax);
      ny    = cur_y_q + 3'd1;
    end
  end

  // Move sequencing, cursor update and auto-repeat timing.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    old_x_d = old_x_q;
    old_y_d = old_y_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    case (state_q)
      StInit: begin
        if (xfer) state_d = StIdle;
      end
      StIdle: begin
        if (!lock && any_key) begin
          cnt_d = rpt_q ? RateLoad : DelayLoad;
          if (mv_ok) begin
            old_x_d = cur_x_q;
            old_y_d = cur_y_q;
            cur_x_d = nx;
            cur_y_d = ny;
            state_d = StErase;
          end else begin
            // Blocked at the edge: still pace retries with the repeat timer.
            state_d = StHold;
          end
        end
      end
      StErase: begin
        if (xfer) state_d = StDraw;
      end
      StDraw: begin
        if (xfer) state_d = StHold;
      end
      StHold: begin
        if (!any_key) begin
          rpt_d   = 1'b0;
          state_d = StIdle;
        end else if (lock) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          rpt_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Request registers follow the state being entered, so they hold steady while stalled.
  always_comb begin
    req_d   = 1'b0;
    dx_d    = dx_q;
    dy_d    = dy_q;
    erase_d = erase_q;
    case (state_d)
      StInit: begin
        req_d   = 1'b1;
        dx_d    = 3'd0;
        dy_d    = 3'd0;
        erase_d = 1'b0;
      end
      StErase: begin
        req_d   = 1'b1;
        dx_d    = old_x_d;
        dy_d    = old_y_d;
        erase_d = 1'b1;
      end
      StDraw: begin
        req_d   = 1'b1;
        dx_d    = cur_x_d;
        dy_d    = cur_y_d;
        erase_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StInit;
      cur_x_q <= 3'd0;
      cur_y_q <= 3'd0;
      old_x_q <= 3'd0;
      old_y_q <= 3'd0;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
      req_q   <= 1'b0;
      dx_q    <= 3'd0;
      dy_q    <= 3'd0;
      erase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      old_x_q <= old_x_d;
      old_y_q <= old_y_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      req_q   <= req_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      erase_q <= erase_d;
    end
  end

  assign draw_req   = req_q;
  assign draw_x     = dx_q;
  assign draw_y     = dy_q;
  assign draw_erase = erase_q;
  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign busy       = (state_q == StInit) || (state_q == StErase) || (state_q == StDraw);

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Directed bench for cursor_move_ctrl with short repeat timing.
module tb_cursor_move_ctrl;

  localparam int unsigned Delay = 20;
  localparam int unsigned Rate  = 5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_right = 1'b0, key_left = 1'b0, key_up = 1'b0, key_down = 1'b0;
  logic       lock = 1'b0;
  logic       draw_ready = 1'b1;
  logic       draw_req, draw_erase, busy;
  logic [2:0] draw_x, draw_y, cur_x, cur_y;

  int checks = 0;
  int failures = 0;

  logic [6:0] xq[$];  // {x, y, erase} of each accepted request

  cursor_move_ctrl #(
    .REPEAT_DELAY(Delay),
    .REPEAT_RATE (Rate),
    .COORD_MAX   (7)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_right (key_right),
    .key_left  (key_left),
    .key_up    (key_up),
    .key_down  (key_down),
    .lock      (lock),
    .draw_ready(draw_ready),
    .draw_req  (draw_req),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .draw_erase(draw_erase),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Log every transfer seen on the handshake.
  always @(posedge clk) begin
    if (resetn && draw_req && draw_ready) xq.push_back({draw_x, draw_y, draw_erase});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] xf(input int i);
    if (i < xq.size()) return xq[i];
    return 7'h7f;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    draw_ready = 1'b1;
    cycles(3);
    xq.delete();
    resetn = 1'b1;
    cycles(5);
  endtask

  int t[8];
  int nmv;
  logic [2:0] prev_y;

  initial begin
    // Reset state and the INIT draw.
    cycles(2);
    check_eq("rst_req", {31'd0, draw_req}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    check_eq("rst_cur", {26'd0, cur_x, cur_y}, 32'd0);
    check_eq("rst_draw", {25'd0, draw_x, draw_y, draw_erase}, 32'd0);
    do_reset();
    check_eq("init_cnt", xq.size(), 32'd1);
    check_eq("init_xfer", {25'd0, xf(0)}, {25'd0, 3'd0, 3'd0, 1'b0});
    check_eq("init_busy", {31'd0, busy}, 32'd0);

    // One-cycle right pulse: exactly one move.
    xq.delete();
    key_right = 1'b1;
    cycles(1);
    key_right = 1'b0;
    check_eq("pulse_cur_now", {26'd0, cur_x, cur_y}, {26'd0, 3'd1, 3'd0});
    check_eq("pulse_erase_req", {30'd0, draw_req, draw_erase}, 32'd3);
    check_eq("pulse_busy", {31'd0, busy}, 32'd1);
    cycles(10);
    check_eq("pulse_cur", {26'd0, cur_x, cur_y}, {26'd0, 3'd1, 3'd0});
    check_eq("pulse_cnt", xq.size(), 32'd2);
    check_eq("pulse_x0", {25'd0, xf(0)}, {25'd0, 3'd0, 3'd0, 1'b1});
    check_eq("pulse_x1", {25'd0, xf(1)}, {25'd0, 3'd1, 3'd0, 1'b0});

    // Hold down: first repeat after Delay+3 cycles, then every Rate+3
    // (hold time plus erase, draw and the idle evaluation cycle).
    xq.delete();
    nmv    = 0;
    prev_y = cur_y;
    key_down = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cur_y != prev_y && nmv < 8) begin
        t[nmv] = c;
        nmv++;
      end
      prev_y = cur_y;
    end
    key_down = 1'b0;
    check_eq("rep_moves", nmv, 32'd7);
    check_eq("rep_first_gap", t[1] - t[0], Delay + 3);
    for (int k = 2; k < 7; k++) check_eq("rep_gap", t[k] - t[k-1], Rate + 3);
    check_eq("rep_cur", {26'd0, cur_x, cur_y}, {26'd0, 3'd1, 3'd7});
    check_eq("rep_xfers", xq.size(), 32'd14);
    check_eq("rep_last", {25'd0, xf(13)}, {25'd0, 3'd1, 3'd7, 1'b0});
    cycles(3);

    // Left+up at the corner: left wins and is blocked, nothing drawn.
    do_reset();
    xq.delete();
    key_left = 1'b1;
    key_up   = 1'b1;
    cycles(30);
    check_eq("corner_xfers", xq.size(), 32'd0);
    check_eq("corner_cur", {26'd0, cur_x, cur_y}, 32'd0);
    check_eq("corner_busy", {30'd0, busy, draw_req}, 32'd0);
    key_left = 1'b0;
    key_up   = 1'b0;
    cycles(3);

    // Right+left together: right wins.
    key_right = 1'b1;
    key_left  = 1'b1;
    cycles(1);
    key_right = 1'b0;
    key_left  = 1'b0;
    cycles(8);
    check_eq("rl_cur", {26'd0, cur_x, cur_y}, {26'd0, 3'd1, 3'd0});
    check_eq("rl_xfers", xq.size(), 32'd2);

    // Stall during ERASE; a key pressed meanwhile is ignored.
    xq.delete();
    draw_ready = 1'b0;
    key_right  = 1'b1;
    cycles(1);
    key_right = 1'b0;
    key_up    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_eq("stall_req", {25'd0, draw_req, draw_x, draw_y}, {25'd0, 1'b1, 3'd1, 3'd0});
      check_eq("stall_erase", {31'd0, draw_erase}, 32'd1);
      cycles(1);
    end
    check_eq("stall_cur", {26'd0, cur_x, cur_y}, {26'd0, 3'd2, 3'd0});
    key_left   = 1'b1;
    draw_ready = 1'b1;
    key_up     = 1'b0;
    key_left   = 1'b0;
    cycles(6);
    check_eq("stall_xfers", xq.size(), 32'd2);
    check_eq("stall_x0", {25'd0, xf(0)}, {25'd0, 3'd1, 3'd0, 1'b1});
    check_eq("stall_x1", {25'd0, xf(1)}, {25'd0, 3'd2, 3'd0, 1'b0});
    check_eq("stall_final", {26'd0, cur_x, cur_y}, {26'd0, 3'd2, 3'd0});

    // Lock refuses moves.
    xq.delete();
    lock      = 1'b1;
    key_right = 1'b1;
    cycles(30);
    check_eq("lock_xfers", xq.size(), 32'd0);
    check_eq("lock_cur", {26'd0, cur_x, cur_y}, {26'd0, 3'd2, 3'd0});
    key_right = 1'b0;
    cycles(1);
    lock = 1'b0;
    cycles(3);

    // Reset while DRAW is stalled.
    key_right = 1'b1;
    cycles(1);
    key_right = 1'b0;
    cycles(1);
    draw_ready = 1'b0;
    cycles(3);
    check_eq("draw_stall", {25'd0, draw_req, draw_x, draw_y},
             {25'd0, 1'b1, 3'd3, 3'd0});
    check_eq("draw_stall_erase", {31'd0, draw_erase}, 32'd0);
    resetn = 1'b0;
    cycles(1);
    check_eq("mid_rst_req", {31'd0, draw_req}, 32'd0);
    check_eq("mid_rst_cur", {26'd0, cur_x, cur_y}, 32'd0);
    xq.delete();
    resetn     = 1'b1;
    draw_ready = 1'b1;
    cycles(5);
    check_eq("re_init_cnt", xq.size(), 32'd1);
    check_eq("re_init_xfer", {25'd0, xf(0)}, 32'd0);
    check_eq("re_init_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cursor_move_ctrl.md
Name: cursor_move_ctrl

Overview:
Owns the board cursor position (8x8 reversi grid) and sequences each cursor move.
- Converts held direction keys into single moves, with auto-repeat after a hold delay.
- Drives the cell-redraw engine through a req/ready handshake: first erase the cursor at the old cell, then draw it at the new cell.
- Sits between the synchronized key inputs and the VGA cell-draw engine. `lock` gates moves during flips or opponent turns.

Parameters:
- REPEAT_DELAY, 25000000, cycles a key must be held after a move before the first auto-repeat.
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeats. Requires REPEAT_DELAY >= REPEAT_RATE >= 1.
- COORD_MAX, 7, highest legal coordinate on both axes.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset: synchronous, active-low; clock clk.
- key_right  in  1  level, already synchronized/debounced, active-high.
- key_left  in  1  as above.
- key_up  in  1  as above. Up decrements y.
- key_down  in  1  as above. Down increments y.
- lock  in  1  high = new moves refused.
- draw_ready  in  1  draw engine can accept a request.
- draw_req  out  1  request to draw engine.
- draw_x  out  3  cell x for the request.
- draw_y  out  3  cell y for the request.
- draw_erase  out  1  1 = restore background at cell; 0 = draw cursor.
- cur_x  out  3  current cursor x.
- cur_y  out  3  current cursor y.
- busy  out  1  high in INIT, ERASE and DRAW.

Behaviour:
- Reset values: cur_x=0, cur_y=0, draw_req=0, draw_x=0, draw_y=0, draw_erase=0, state=INIT, repeat counter=0, repeat flag=0.
- Handshake:
  - A transfer occurs on a clock edge where draw_req & draw_ready are both high.
  - draw_req, draw_x, draw_y and draw_erase are registered. They stay stable until the transfer.
  - draw_req drops the cycle after the transfer unless the next state issues a new request.
- States:
  - INIT: req (0,0), erase=0. On transfer -> IDLE. Draws the cursor after every reset.
  - IDLE:
    - If lock=1 or no key is held, stay.
    - Otherwise select a direction with priority right > left > up > down.
    - If the move stays in range (right: x<COORD_MAX; left: x>0; up: y>0; down: y<COORD_MAX):
      - latch old=(cur_x,cur_y);
      - update cur_x/cur_y by ±1 at that same edge;
      - -> ERASE.
    - If the move is blocked at the edge: cur is unchanged, no draw request, -> HOLD.
    - In both cases, load the counter with REPEAT_DELAY-1 when repeat flag=0, or REPEAT_RATE-1 when repeat flag=1.
  - ERASE: req (old), erase=1. On transfer -> DRAW.
  - DRAW: req (cur), erase=0. On transfer -> HOLD.
  - HOLD:
    - If no key is held: clear repeat flag, -> IDLE.
    - Else if lock=1: -> IDLE, repeat flag kept.
    - Else decrement counter. When it is 0: set repeat flag, -> IDLE. The next move is evaluated there, costing one cycle.
- The counter runs only in HOLD. It is sized to hold REPEAT_DELAY-1.
- Key changes during ERASE/DRAW are ignored. The direction is re-evaluated only in IDLE.
- lock rising during ERASE/DRAW does not abort. The in-flight pair completes.
- Minimum time from key press to cur update: 1 cycle after IDLE samples the key.
- Simultaneous opposite keys: the priority rule applies (right+left -> right).
- A reset mid-handshake forces draw_req=0 at the next edge, then re-enters INIT. The old cursor image on screen is not erased.

Test Plan:
- Reset, draw_ready=1 -> one INIT transfer (0,0,erase=0); busy drops; cur=(0,0).
- Pulse key_right for 1 cycle from (0,0), draw_ready=1 -> cur=(1,0); transfers in order (0,0,erase=1) then (1,0,erase=0); exactly one move.
- Hold key_down with REPEAT_DELAY=20, REPEAT_RATE=5 -> moves at y=1, then ~20 cycles later y=2, then every ~5 cycles, stopping at y=7 with no requests once blocked.
- From (0,0) press key_left and key_up together -> no draw request, cur stays (0,0), controller in HOLD until release.
- Hold draw_ready=0 for 10 cycles during ERASE -> draw_req and draw_x/draw_y/draw_erase stable throughout; completes after ready rises; a key_up pressed meanwhile is ignored.
- lock=1 with key_right held -> no move. Assert resetn=0 during DRAW with draw_ready=0 -> next cycle draw_req=0, cur=(0,0), INIT request follows.
